// File: rtl/ura_scoreboard.sv
// URA pending-write scoreboard: one latency counter per mapped URA, with combinational busy lookup.
// Optional stall-cycle counter is enabled by defining URA_SB_PERF_EN.
module ura_scoreboard #(
  parameter int NUM_SRC = 2,
  parameter int LAT_W   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [6:0]           issue_ura,
  input  logic [LAT_W-1:0]     issue_lat,
  input  logic                 release_valid,
  input  logic [6:0]           release_ura,
  input  logic                 flush,
  input  logic [7*NUM_SRC-1:0] src_ura,
  output logic [NUM_SRC-1:0]   src_busy,
  output logic                 issue_err,
  output logic [31:0]          perf_stall_cnt
);

  localparam int               NUM_ENT  = 37;
  localparam logic [LAT_W-1:0] LAT_HOLD = '1;
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  // GRF 1..31, CP0 12..15 (011xx) and HI/LO are the only tracked URAs
  function automatic logic ura_mapped(input logic [6:0] ura);
    logic ok;
    case (ura[6:5])
      2'b00:   ok = (ura[4:0] != 5'd0);
      2'b01:   ok = (ura[4:2] == 3'b011);
      2'b10:   ok = (ura[4:1] == 4'd0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [5:0] ura_index(input logic [6:0] ura);
    logic [5:0] idx;
    if (!ura_mapped(ura)) begin
      idx = 6'd0;
    end else begin
      case (ura[6:5])
        2'b00:   idx = {1'b0, ura[4:0]} - 6'd1;
        2'b01:   idx = 6'd31 + {4'd0, ura[1:0]};
        2'b10:   idx = 6'd35 + {5'd0, ura[0]};
        default: idx = 6'd0;
      endcase
    end
    return idx;
  endfunction

  logic [LAT_W-1:0] cnt_q [NUM_ENT];
  logic [LAT_W-1:0] cnt_d [NUM_ENT];
  logic             issue_map_s;
  logic             rel_map_s;
  logic [5:0]       issue_idx_s;
  logic [5:0]       rel_idx_s;
  logic             issue_err_q;
  logic             issue_err_d;

  assign issue_map_s = ura_mapped(issue_ura);
  assign rel_map_s   = ura_mapped(release_ura);
  assign issue_idx_s = ura_index(issue_ura);
  assign rel_idx_s   = ura_index(release_ura);

  // Priority per entry: flush, then issue, then release, then countdown (HOLD never counts)
  always_comb begin
    for (int e = 0; e < NUM_ENT; e++) begin
      if (flush) begin
        cnt_d[e] = '0;
      end else if (issue_valid && issue_map_s && (issue_idx_s == 6'(e))) begin
        cnt_d[e] = issue_lat;
      end else if (release_valid && rel_map_s && (rel_idx_s == 6'(e))) begin
        cnt_d[e] = '0;
      end else if ((cnt_q[e] != '0) && (cnt_q[e] != LAT_HOLD)) begin
        cnt_d[e] = cnt_q[e] - LAT_ONE;
      end else begin
        cnt_d[e] = cnt_q[e];
      end
    end
  end

  // GRF 0 is a legal but untracked target, so it never raises an error
  always_comb begin
    if (issue_valid && !issue_map_s && (issue_ura != 7'd0)) begin
      issue_err_d = 1'b1;
    end else begin
      issue_err_d = 1'b0;
    end
  end

  // Counter and error state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int e = 0; e < NUM_ENT; e++) begin
        cnt_q[e] <= '0;
      end
      issue_err_q <= 1'b0;
    end else begin
      for (int e = 0; e < NUM_ENT; e++) begin
        cnt_q[e] <= cnt_d[e];
      end
      issue_err_q <= issue_err_d;
    end
  end

  // Lookups see only the registered counters: no bypass of a same-cycle issue
  always_comb begin
    src_busy = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ura_mapped(src_ura[7*i +: 7])) begin
        src_busy[i] = (cnt_q[ura_index(src_ura[7*i +: 7])] != '0);
      end else begin
        src_busy[i] = 1'b0;
      end
    end
  end

  assign issue_err = issue_err_q;

`ifdef URA_SB_PERF_EN
  logic [31:0] perf_q;
  logic [31:0] perf_d;

  // Saturating stall counter; flush deliberately leaves it alone
  always_comb begin
    if ((|src_busy) && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end else begin
      perf_d = perf_q;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ura_scoreboard.sv
// Self-checking bench for ura_scoreboard: directed scenarios then random traffic vs. a URA-indexed model.
module tb_ura_scoreboard;

  localparam int NUM_SRC = 2;
  localparam int LAT_W   = 3;
  localparam int HOLD    = 7;

  logic         clk = 1'b0;
  logic         reset;
  logic         issue_valid;
  logic [6:0]   issue_ura;
  logic [2:0]   issue_lat;
  logic         release_valid;
  logic [6:0]   release_ura;
  logic         flush;
  logic [6:0]   src0;
  logic [6:0]   src1;
  logic [13:0]  src_ura;
  logic [1:0]   src_busy;
  logic         issue_err;
  logic [31:0]  perf_stall_cnt;

  int           n_cmp = 0;
  int           n_err = 0;
  int           mcnt [128];
  bit           merr;
  longint       mperf;

  assign src_ura = {src1, src0};

  always #5 clk = ~clk;

  ura_scoreboard #(.NUM_SRC(NUM_SRC), .LAT_W(LAT_W)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ura(issue_ura),
    .issue_lat(issue_lat), .release_valid(release_valid), .release_ura(release_ura),
    .flush(flush), .src_ura(src_ura), .src_busy(src_busy), .issue_err(issue_err),
    .perf_stall_cnt(perf_stall_cnt)
  );

  function automatic bit m_mapped(int u);
    int g = u / 32;
    int r = u % 32;
    if (g == 0) return r >= 1;
    if (g == 1) return (r >= 12) && (r <= 15);
    if (g == 2) return r <= 1;
    return 1'b0;
  endfunction

  function automatic bit m_busy(int u);
    return m_mapped(u) && (mcnt[u] != 0);
  endfunction

  function automatic logic [31:0] m_perf();
`ifdef URA_SB_PERF_EN
    return (mperf > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : mperf[31:0];
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int u = 0; u < 128; u++) mcnt[u] = 0;
    merr  = 1'b0;
    mperf = 0;
  endtask

  // Apply one clock edge to the model using the inputs currently driven
  task automatic model_step();
    if (m_busy(int'(src0)) || m_busy(int'(src1))) mperf++;
    merr = issue_valid && !m_mapped(int'(issue_ura)) && (issue_ura != 7'd0);
    if (flush) begin
      for (int u = 0; u < 128; u++) mcnt[u] = 0;
    end else begin
      for (int u = 0; u < 128; u++)
        if (mcnt[u] != 0 && mcnt[u] != HOLD) mcnt[u]--;
      if (release_valid && m_mapped(int'(release_ura))) mcnt[release_ura] = 0;
      if (issue_valid && m_mapped(int'(issue_ura))) mcnt[issue_ura] = int'(issue_lat);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("issue_err", {31'd0, issue_err}, {31'd0, merr});
    chk("busy0", {31'd0, src_busy[0]}, {31'd0, m_busy(int'(src0))});
    chk("busy1", {31'd0, src_busy[1]}, {31'd0, m_busy(int'(src1))});
    chk("perf", perf_stall_cnt, m_perf());
  endtask

  task automatic idle();
    issue_valid   = 1'b0;
    release_valid = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic issue(input logic [6:0] u, input logic [2:0] lat);
    issue_valid = 1'b1;
    issue_ura   = u;
    issue_lat   = lat;
  endtask

  function automatic logic [6:0] rand_ura();
    case ($urandom_range(0, 3))
      0:       return 7'($urandom_range(0, 7));
      1:       return 7'(32 + $urandom_range(10, 16));
      2:       return 7'(64 + $urandom_range(0, 3));
      default: return 7'($urandom_range(0, 127));
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    idle();
    issue_ura = 7'd0; issue_lat = 3'd0; release_ura = 7'd0;
    src0 = 7'd8; src1 = 7'd0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {30'd0, src_busy}, 32'd0);
    chk("rst_err", {31'd0, issue_err}, 32'd0);
    chk("rst_perf", perf_stall_cnt, 32'd0);
    reset = 1'b1;

    // GRF 8 lat 3: busy for exactly three cycles after the issue edge
    issue(7'd8, 3'd3); tick(); idle();
    chk("g8_c1", {31'd0, src_busy[0]}, 32'd1);
    tick(); tick();
    chk("g8_c3", {31'd0, src_busy[0]}, 32'd1);
    tick();
    chk("g8_c4", {31'd0, src_busy[0]}, 32'd0);

    // HI held until release; LO issue+release same cycle -> issue wins
    src0 = 7'd64; issue(7'd64, 3'd7); tick(); idle();
    repeat (20) tick();
    chk("hi_hold", {31'd0, src_busy[0]}, 32'd1);
    release_valid = 1'b1; release_ura = 7'd64; tick(); idle();
    chk("hi_rel", {31'd0, src_busy[0]}, 32'd0);
    src1 = 7'd65; issue(7'd65, 3'd2); release_valid = 1'b1; release_ura = 7'd65;
    tick(); idle();
    chk("lo_c1", {31'd0, src_busy[1]}, 32'd1);
    tick();
    chk("lo_c2", {31'd0, src_busy[1]}, 32'd1);
    tick();
    chk("lo_c3", {31'd0, src_busy[1]}, 32'd0);

    // WAW: later short issue overrides earlier long one
    src0 = 7'd5; issue(7'd5, 3'd4); tick(); idle(); tick();
    issue(7'd5, 3'd1); tick(); idle();
    chk("waw_c1", {31'd0, src_busy[0]}, 32'd1);
    tick();
    chk("waw_c2", {31'd0, src_busy[0]}, 32'd0);

    // Unmapped targets error, GRF 0 is silent
    src0 = 7'd99; src1 = 7'd35;
    issue(7'b1100011, 3'd5); tick(); idle();
    chk("err_g3", {31'd0, issue_err}, 32'd1);
    tick();
    chk("err_clr", {31'd0, issue_err}, 32'd0);
    issue(7'd35, 3'd5); tick(); idle();
    chk("err_cp3", {31'd0, issue_err}, 32'd1);
    chk("cp3_busy", {31'd0, src_busy[1]}, 32'd0);
    src0 = 7'd0; issue(7'd0, 3'd5); tick(); idle();
    chk("grf0_err", {31'd0, issue_err}, 32'd0);
    chk("grf0_busy", {31'd0, src_busy[0]}, 32'd0);

    // Flush beats same-cycle issue
    src0 = 7'd46; src1 = 7'd31;
    issue(7'd46, 3'd7); tick(); issue(7'd31, 3'd7); tick(); idle();
    chk("pend_both", {30'd0, src_busy}, 32'd3);
    flush = 1'b1; issue(7'd2, 3'd3); tick(); idle();
    chk("flush_busy", {30'd0, src_busy}, 32'd0);
    src0 = 7'd2; tick();
    chk("flush_g2", {31'd0, src_busy[0]}, 32'd0);

    // Asynchronous reset mid-countdown
    issue(7'd2, 3'd5); tick(); idle();
    #2 reset = 1'b0;
    #1;
    model_clear();
    chk("arst_busy", {30'd0, src_busy}, 32'd0);
    chk("arst_perf", perf_stall_cnt, 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Five stall cycles on source 1
    src0 = 7'd0; src1 = 7'd9; issue(7'd9, 3'd7); tick(); idle();
    repeat (5) tick();
`ifdef URA_SB_PERF_EN
    chk("perf5", perf_stall_cnt, 32'd5);
`else
    chk("perf0", perf_stall_cnt, 32'd0);
`endif
    release_valid = 1'b1; release_ura = 7'd9; tick(); idle();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      src0          = rand_ura();
      src1          = rand_ura();
      issue_valid   = ($urandom_range(0, 1) == 0);
      issue_ura     = rand_ura();
      issue_lat     = 3'($urandom_range(0, 7));
      release_valid = ($urandom_range(0, 3) == 0);
      release_ura   = rand_ura();
      flush         = ($urandom_range(0, 31) == 0);
      tick();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
